fibo_seq_ctrl: RTL and testbench
================================

Name: fibo_seq_ctrl

Overview:
Sequencing controller for the Fibonacci datapath: a 4-entry register file with 2 read ports and 1 write port, plus a 3-bit-opcode ALU that returns zero_flag.
- Accepts a term count n through a valid/ready request handshake.
- Issues one micro-op per cycle to the datapath.
- Streams each Fibonacci term out under valid/ready backpressure.
- Pulses done when finished.
- Sits between the host-side request logic and the register file/ALU pair. It replaces ad-hoc start/done sequencing.

Parameters:
- N_W, 8: width of requested term count n and of ld_value.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start_valid, input, 1: request present; n is valid.
- start_ready, output, 1: controller can accept a request (IDLE only).
- n, input, N_W: number of terms to produce.
- zero_flag, input, 1: ALU result == 0. Combinational, same cycle as the micro-op.
- alu_opcode, output, 3: 000 PASS_A, 001 ADD, 010 DEC_A (A-1), 011 CLR (0). Other codes unused.
- rd_addr1, output, 2: register file read port A.
- rd_addr2, output, 2: register file read port B.
- wrt_addr, output, 2: register file write address.
- wrt_en, output, 1: write on next rising clk edge.
- load_data, output, 1: write port takes ld_value instead of the ALU result.
- ld_value, output, N_W: load operand, zero-extended by the datapath.
- term_valid, output, 1: ALU result currently equals the next term (PASS of R0).
- term_ready, input, 1: consumer accepts the term.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse at end of request.

Behaviour:
Register map (fixed): R0 = a (current term), R1 = b (next term), R2 = remaining count, R3 = temp.

The n value is captured into an internal register n_q on accept (start_valid && start_ready). ld_value is driven from n_q in LOAD and is constant 1 in INIT1.

Micro-op outputs are a Moore decode of the state. Any field not listed below defaults to: opcode PASS_A, rd_addr1 = rd_addr2 = wrt_addr = 0, wrt_en = 0, load_data = 0, ld_value = 0.

States and transitions:
- IDLE: start_ready = 1.
  - Accept -> LOAD. Otherwise stay.
- LOAD: wrt_addr = R2, wrt_en = 1, load_data = 1, ld_value = n_q. -> CLR0.
- CLR0: opcode CLR, wrt_addr = R0, wrt_en = 1. -> INIT1.
- INIT1: wrt_addr = R1, wrt_en = 1, load_data = 1, ld_value = 1. -> CHECK.
- CHECK: opcode PASS_A, rd_addr1 = R2.
  - zero_flag = 1 -> DONE.
  - zero_flag = 0 -> EMIT.
- EMIT: opcode PASS_A, rd_addr1 = R0, term_valid = 1.
  - Hold all outputs until term_ready = 1, then -> ADD.
  - term_ready may be high on the first EMIT cycle; this gives zero stall.
- ADD: opcode ADD, rd_addr1 = R0, rd_addr2 = R1, wrt_addr = R3, wrt_en = 1. -> MOV0.
- MOV0: opcode PASS_A, rd_addr1 = R1, wrt_addr = R0, wrt_en = 1. -> MOV1.
- MOV1: opcode PASS_A, rd_addr1 = R3, wrt_addr = R1, wrt_en = 1. -> DEC.
- DEC: opcode DEC_A, rd_addr1 = R2, wrt_addr = R2, wrt_en = 1. -> CHECK.
- DONE: done = 1 for exactly one cycle. -> IDLE.

Timing:
- Per term, with no stall: 6 cycles (CHECK, EMIT, ADD, MOV0, MOV1, DEC).
- Accept-to-first-term_valid: 5 cycles after the accept edge (IDLE -> LOAD -> CLR0 -> INIT1 -> CHECK -> EMIT).

Boundary conditions:
- n = 0: no term_valid is ever asserted. done is asserted 5 cycles after the accept edge (LOAD, CLR0, INIT1, CHECK, DONE).
- start_valid while busy: ignored, since start_ready = 0. n is not sampled.
- Same cycle as done: start_ready = 0 in DONE. A new request is accepted in the following IDLE cycle at the earliest.
- term_ready while term_valid = 0: ignored.
- Term overflow beyond the datapath width: wraps in the datapath. The controller is unaffected.
- rst_n low at any time, including mid-EMIT or mid-write: state goes to IDLE immediately.
  - Outputs are at idle defaults while in reset.
  - Reset values: start_ready = 1 (IDLE), busy = 0, done = 0, term_valid = 0, wrt_en = 0, load_data = 0, alu_opcode = 000, all addresses = 0, ld_value = 0, n_q = 0.
- Unreachable state encodings: next state = IDLE, outputs at idle defaults.

Decomposition:
Package fibo_pkg holds:
- ALU opcode constants (PASS_A, ADD, DEC_A, CLR).
- Register index constants (R_A = 0, R_B = 1, R_CNT = 2, R_TMP = 3).
- State enum (IDLE, LOAD, CLR0, INIT1, CHECK, EMIT, ADD, MOV0, MOV1, DEC, DONE).
- Micro-op struct type.

One sub-module is natural: fibo_uop_decode, a purely combinational map from state to micro-op fields. It is instantiated once. The sequential FSM, n_q and the handshakes stay in fibo_seq_ctrl.

Test Plan:
- n = 5, term_ready tied high, with a behavioural register file/ALU model -> terms 0, 1, 1, 2, 3 on consecutive term_valid beats 6 cycles apart; done 1 cycle wide; busy drops the cycle after done.
- n = 0 -> zero term_valid beats; done exactly 5 cycles after the accept edge; R2 in the model = 0.
- n = 3, term_ready low for 4 cycles on the second term -> term_valid held; alu_opcode = 000, rd_addr1 = 0, wrt_en = 0 stable throughout; terms 0, 1, 1; total duration +4 cycles versus unstalled.
- start_valid pulsed with n = 7 during an active n = 4 run -> ignored; exactly 4 terms and one done. A request with n = 2 in the cycle after done -> accepted, terms 0, 1.
- rst_n asserted asynchronously mid-ADD during an n = 6 run -> outputs at idle defaults immediately, busy = 0. Deassert, then request n = 2 -> clean run, terms 0, 1.
- n = 255 (N_W = 8) -> 255 terms, and the 256th CHECK sees zero_flag = 1; verify the R2 decrement sequence 255..0 via the model's write log.

Source files
------------

// File: rtl/fibo_pkg.sv
// fibo_pkg: opcodes, register map, FSM states and micro-op type shared by the Fibonacci sequencer.
package fibo_pkg;
  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_DEC_A  = 3'b010;
  localparam logic [2:0] OP_CLR    = 3'b011;
  localparam logic [1:0] R_A   = 2'd0;
  localparam logic [1:0] R_B   = 2'd1;
  localparam logic [1:0] R_CNT = 2'd2;
  localparam logic [1:0] R_TMP = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_CLR0  = 4'd2,
    S_INIT1 = 4'd3,
    S_CHECK = 4'd4,
    S_EMIT  = 4'd5,
    S_ADD   = 4'd6,
    S_MOV0  = 4'd7,
    S_MOV1  = 4'd8,
    S_DEC   = 4'd9,
    S_DONE  = 4'd10
  } state_e;
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] rd_addr1;
    logic [1:0] rd_addr2;
    logic [1:0] wrt_addr;
    logic       wrt_en;
    logic       load_data;
    logic       term_valid;
    logic       start_ready;
    logic       busy;
    logic       done;
  } uop_t;
endpackage

// File: rtl/fibo_seq_ctrl_if.sv
// fibo_seq_ctrl_if: request, micro-op and term-stream signals between the sequencer and its environment.
interface fibo_seq_ctrl_if #(parameter int N_W = 8);
  logic           start_valid;
  logic           start_ready;
  logic [N_W-1:0] n;
  logic           zero_flag;
  logic [2:0]     alu_opcode;
  logic [1:0]     rd_addr1;
  logic [1:0]     rd_addr2;
  logic [1:0]     wrt_addr;
  logic           wrt_en;
  logic           load_data;
  logic [N_W-1:0] ld_value;
  logic           term_valid;
  logic           term_ready;
  logic           busy;
  logic           done;
  modport master (
    input  start_valid, n, zero_flag, term_ready,
    output start_ready, alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en,
           load_data, ld_value, term_valid, busy, done
  );
  modport slave (
    output start_valid, n, zero_flag, term_ready,
    input  start_ready, alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en,
           load_data, ld_value, term_valid, busy, done
  );
endinterface

// File: rtl/fibo_uop_decode.sv
// fibo_uop_decode: Moore map from sequencer state to the datapath micro-op and handshake flags.
module fibo_uop_decode
  import fibo_pkg::*;
#(parameter int N_W = 8) (
  input  state_e         i_state,
  input  logic [N_W-1:0] i_n_q,
  output uop_t           o_uop,
  output logic [N_W-1:0] o_ld_value
);
  always_comb begin
    o_uop = '0;
    o_uop.busy = 1'b1;
    o_ld_value = '0;
    case (i_state)
      S_IDLE: begin
        o_uop.busy = 1'b0;
        o_uop.start_ready = 1'b1;
      end
      S_LOAD: begin
        o_uop.wrt_addr = R_CNT;
        o_uop.wrt_en = 1'b1;
        o_uop.load_data = 1'b1;
        o_ld_value = i_n_q;
      end
      S_CLR0: begin
        o_uop.opcode = OP_CLR;
        o_uop.wrt_addr = R_A;
        o_uop.wrt_en = 1'b1;
      end
      S_INIT1: begin
        o_uop.wrt_addr = R_B;
        o_uop.wrt_en = 1'b1;
        o_uop.load_data = 1'b1;
        o_ld_value = N_W'(1);
      end
      S_CHECK: o_uop.rd_addr1 = R_CNT;
      S_EMIT: begin
        o_uop.rd_addr1 = R_A;
        o_uop.term_valid = 1'b1;
      end
      S_ADD: begin
        o_uop.opcode = OP_ADD;
        o_uop.rd_addr1 = R_A;
        o_uop.rd_addr2 = R_B;
        o_uop.wrt_addr = R_TMP;
        o_uop.wrt_en = 1'b1;
      end
      S_MOV0: begin
        o_uop.rd_addr1 = R_B;
        o_uop.wrt_addr = R_A;
        o_uop.wrt_en = 1'b1;
      end
      S_MOV1: begin
        o_uop.rd_addr1 = R_TMP;
        o_uop.wrt_addr = R_B;
        o_uop.wrt_en = 1'b1;
      end
      S_DEC: begin
        o_uop.opcode = OP_DEC_A;
        o_uop.rd_addr1 = R_CNT;
        o_uop.wrt_addr = R_CNT;
        o_uop.wrt_en = 1'b1;
      end
      S_DONE: o_uop.done = 1'b1;
      // stray encodings stay inert and refuse requests until the FSM is back in IDLE
      default: o_uop.busy = 1'b0;
    endcase
  end
endmodule

// File: rtl/fibo_seq_ctrl.sv
// fibo_seq_ctrl: sequences register-file/ALU micro-ops to stream n Fibonacci terms per request.
module fibo_seq_ctrl
  import fibo_pkg::*;
#(parameter int N_W = 8) (
  input logic              clk,
  input logic              rst_n,
  fibo_seq_ctrl_if.master  bus
);
  state_e         r_state;
  state_e         w_next;
  logic [N_W-1:0] r_n_q;
  logic [N_W-1:0] w_ld_value;
  uop_t           w_uop;
  logic           w_accept;
  assign w_accept = bus.start_valid && w_uop.start_ready;
  fibo_uop_decode #(.N_W(N_W)) u_dec (
    .i_state   (r_state),
    .i_n_q     (r_n_q),
    .o_uop     (w_uop),
    .o_ld_value(w_ld_value)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n_q <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_n_q <= bus.n;
    end
  end
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_CLR0;
      S_CLR0:  w_next = S_INIT1;
      S_INIT1: w_next = S_CHECK;
      S_CHECK: w_next = bus.zero_flag ? S_DONE : S_EMIT;
      S_EMIT:  w_next = bus.term_ready ? S_ADD : S_EMIT;
      S_ADD:   w_next = S_MOV0;
      S_MOV0:  w_next = S_MOV1;
      S_MOV1:  w_next = S_DEC;
      S_DEC:   w_next = S_CHECK;
      default: w_next = S_IDLE;
    endcase
  end
  assign bus.start_ready = w_uop.start_ready;
  assign bus.alu_opcode  = w_uop.opcode;
  assign bus.rd_addr1    = w_uop.rd_addr1;
  assign bus.rd_addr2    = w_uop.rd_addr2;
  assign bus.wrt_addr    = w_uop.wrt_addr;
  assign bus.wrt_en      = w_uop.wrt_en;
  assign bus.load_data   = w_uop.load_data;
  assign bus.ld_value    = w_ld_value;
  assign bus.term_valid  = w_uop.term_valid;
  assign bus.busy        = w_uop.busy;
  assign bus.done        = w_uop.done;
endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// tb_fibo_seq_ctrl: directed bench with a behavioural register file/ALU around fibo_seq_ctrl.
module tb_fibo_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  logic [7:0] rf [4];
  logic [7:0] w_a, w_b, res;
  logic [7:0] terms [$];
  int tcyc [$];
  logic [7:0] r2_log [$];
  fibo_seq_ctrl_if #(.N_W(8)) bus ();
  fibo_seq_ctrl #(.N_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    w_a = rf[bus.rd_addr1];
    w_b = rf[bus.rd_addr2];
    res = bus.alu_opcode == 3'b001 ? w_a + w_b :
          bus.alu_opcode == 3'b010 ? w_a - 8'd1 :
          bus.alu_opcode == 3'b011 ? 8'd0 : w_a;
  end
  assign bus.zero_flag = (res == 8'd0);
  always @(posedge clk) begin
    if (bus.wrt_en) begin
      rf[bus.wrt_addr] <= bus.load_data ? bus.ld_value : res;
      if (bus.wrt_addr == 2'd2) r2_log.push_back(bus.load_data ? bus.ld_value : res);
    end
  end
  always @(negedge clk) begin
    if (bus.term_valid && bus.term_ready) begin
      terms.push_back(res);
      tcyc.push_back(cyc);
    end
    if (bus.done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outv();
    return {9'd0, bus.start_ready, bus.busy, bus.done, bus.term_valid, bus.wrt_en, bus.load_data,
            bus.alu_opcode, bus.rd_addr1, bus.rd_addr2, bus.wrt_addr, bus.ld_value};
  endfunction
  task automatic clear();
    terms.delete();
    tcyc.delete();
    r2_log.delete();
    n_done = 0;
  endtask
  task automatic req(input logic [7:0] nv, output int a);
    a = -1;
    @(posedge clk); #1;
    bus.start_valid = 1'b1;
    bus.n = nv;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.start_ready) begin
        a = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.n = 8'hAA;
    chk("accept_seen", 32'(a >= 0), 32'd1);
  endtask
  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        d = cyc;
        break;
      end
    end
    chk("done_seen", 32'(d >= 0), 32'd1);
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic chk_terms(input string tag, input int a, input int f[], input int gap[]);
    chk({tag, "_count"}, terms.size(), f.size());
    for (int i = 0; i < f.size(); i++) begin
      chk({tag, "_val"}, 32'(terms[i]), f[i]);
      chk({tag, "_cyc"}, tcyc[i], a + gap[i]);
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a, a2, d, d2, bad;
    logic [7:0] fa, fb, ft;
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.n = 8'd0;
    bus.term_ready = 1'b1;
    @(negedge clk);
    chk("reset_outputs", outv(), 32'h0040_0000);
    @(negedge clk);
    rst_n = 1'b1;
    // n=5, no backpressure: terms every 6 cycles, done one cycle wide
    clear();
    req(8'd5, a);
    wait_done(100, d);
    chk("t1_done_cyc", d, a + 35);
    chk("t1_busy_in_done", bus.busy, 1);
    chk("t1_ready_in_done", bus.start_ready, 0);
    @(negedge clk);
    chk("t1_done_width", bus.done, 0);
    chk("t1_busy_drop", bus.busy, 0);
    chk_terms("t1", a, '{0, 1, 1, 2, 3}, '{5, 11, 17, 23, 29});
    // n=0: straight to DONE, no terms
    clear();
    req(8'd0, a);
    wait_done(50, d);
    chk("t2_done_cyc", d, a + 5);
    chk("t2_terms", terms.size(), 0);
    chk("t2_r2", rf[2], 0);
    // n=3 with second term stalled 4 cycles
    clear();
    req(8'd3, a);
    wait_cyc(a + 6);
    bus.term_ready = 1'b0;
    wait_cyc(a + 11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_stall_outs", {bus.term_valid, bus.alu_opcode, bus.rd_addr1, bus.wrt_en}, {1'b1, 3'b000, 2'b00, 1'b0});
    end
    @(posedge clk); #1;
    bus.term_ready = 1'b1;
    wait_done(100, d);
    chk("t3_done_cyc", d, a + 27);
    chk_terms("t3", a, '{0, 1, 1}, '{5, 15, 21});
    // n=4 with an ignored n=7 request mid-run, then n=2 right after done
    clear();
    req(8'd4, a);
    wait_cyc(a + 8);
    bus.start_valid = 1'b1;
    bus.n = 8'd7;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    wait_done(100, d);
    chk("t4_done_cyc", d, a + 29);
    chk("t4_ready_in_done", bus.start_ready, 0);
    chk("t4_done_count", n_done, 1);
    chk_terms("t4", a, '{0, 1, 1, 2}, '{5, 11, 17, 23});
    clear();
    req(8'd2, a2);
    chk("t4b_accept_cyc", a2, d + 1);
    wait_done(100, d2);
    chk("t4b_done_cyc", d2, a2 + 17);
    chk_terms("t4b", a2, '{0, 1}, '{5, 11});
    // async reset in the middle of ADD, then a clean n=2 run
    clear();
    req(8'd6, a);
    wait_cyc(a + 6);
    chk("t5_in_add", bus.alu_opcode, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", outv(), 32'h0040_0000);
    chk("t5_busy", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_held_in_reset", outv(), 32'h0040_0000);
    rst_n = 1'b1;
    clear();
    req(8'd2, a);
    wait_done(100, d);
    chk("t5_done_cyc", d, a + 17);
    chk_terms("t5", a, '{0, 1}, '{5, 11});
    // n=255: full-width count, terms wrap in the 8-bit datapath
    clear();
    req(8'd255, a);
    wait_done(2000, d);
    chk("t6_done_cyc", d, a + 1535);
    chk("t6_count", terms.size(), 255);
    bad = 0;
    fa = 8'd0;
    fb = 8'd1;
    for (int i = 0; i < 255; i++) begin
      if (terms[i] !== fa) bad++;
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end
    chk("t6_term_errors", bad, 0);
    chk("t6_r2_writes", r2_log.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (r2_log[i] !== 8'(255 - i)) bad++;
    chk("t6_r2_seq_errors", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
